// File: rtl/fp_pkg.sv
// Shared FP32 field layout, integer limits and converter FSM encoding.
package fp_pkg;
   localparam int SIGN_BIT = 31;
   localparam int EXP_MSB  = 30;
   localparam int EXP_LSB  = 23;
   localparam int FRAC_MSB = 22;
   localparam int FRAC_W   = 23;
   localparam int MANT_W   = 24;

   localparam logic [7:0] BIAS    = 8'd127;
   localparam logic [7:0] EXP_INF = 8'hFF;
   // Exponent where the mantissa LSB has weight 1, and where |value| reaches 2^31.
   localparam logic [7:0] EXP_UNITY = BIAS + 8'd23;
   localparam logic [7:0] EXP_EXACT = BIAS + 8'd31;

   localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SHIFT = 1'b1
   } state_t;

   typedef struct packed {
      logic              s;
      logic [7:0]        e;
      logic [MANT_W-1:0] m;
      logic              is_nan;
      logic              is_inf;
   } fp_unpacked_t;
endpackage

// File: rtl/fp_unpack_32.sv
// FP32 field extraction shared with the adder; hidden bit is the OR of the exponent.
module fp_unpack_32
   import fp_pkg::*;
(
   input  logic [31:0]  i_a,
   output fp_unpacked_t o_f
);
   logic [FRAC_W-1:0] w_frac;

   always_comb begin
      w_frac     = i_a[FRAC_MSB:0];
      o_f.s      = i_a[SIGN_BIT];
      o_f.e      = i_a[EXP_MSB:EXP_LSB];
      o_f.m      = {|i_a[EXP_MSB:EXP_LSB], w_frac};
      o_f.is_nan = (o_f.e == EXP_INF) && (w_frac != '0);
      o_f.is_inf = (o_f.e == EXP_INF) && (w_frac == '0);
   end
endmodule

// File: rtl/fp_to_int_32.sv
// Multicycle FP32 -> INT32 converter (truncating); aligns the mantissa one bit per cycle.
module fp_to_int_32
   import fp_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [31:0] a,
   output logic        busy,
   output logic        done,
   output logic [31:0] result,
   output logic        invalid
);
   fp_unpacked_t w_f;
   state_t       r_state, w_nxt;
   logic         w_accept, w_finish;

   logic [31:0]  r_mag, w_ld_mag;
   logic [4:0]   r_cnt, w_ld_cnt;
   logic         r_dir, w_ld_dir;     // 1 = shift left
   logic         r_byp, w_ld_byp;     // mag already holds the final result
   logic         r_inv, w_ld_inv;
   logic         r_sign;
   logic [31:0]  r_result;
   logic         r_invalid, r_done;

   fp_unpack_32 u_unpack (.i_a(a), .o_f(w_f));

   // Classifier: specials and small values bypass alignment with cnt=0.
   always_comb begin
      w_ld_mag = {8'b0, w_f.m};
      w_ld_cnt = '0;
      w_ld_dir = 1'b0;
      w_ld_byp = 1'b0;
      w_ld_inv = 1'b0;
      if (w_f.is_nan || w_f.is_inf) begin
         w_ld_mag = (w_f.is_nan || !w_f.s) ? INT_MAX : INT_MIN;
         w_ld_byp = 1'b1;
         w_ld_inv = 1'b1;
      end else if (w_f.e == EXP_EXACT && w_f.s && w_f.m[FRAC_MSB:0] == '0) begin
         w_ld_mag = INT_MIN;
         w_ld_byp = 1'b1;
      end else if (w_f.e >= EXP_EXACT) begin
         w_ld_mag = w_f.s ? INT_MIN : INT_MAX;
         w_ld_byp = 1'b1;
         w_ld_inv = 1'b1;
      end else if (w_f.e < BIAS) begin
         w_ld_mag = '0;
         w_ld_byp = 1'b1;
      end else if (w_f.e <= EXP_UNITY) begin
         w_ld_cnt = 5'(EXP_UNITY - w_f.e);
      end else begin
         w_ld_dir = 1'b1;
         w_ld_cnt = 5'(w_f.e - EXP_UNITY);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= ST_IDLE;
      else        r_state <= w_nxt;
   end

   always_comb begin
      w_nxt    = r_state;
      w_accept = 1'b0;
      w_finish = 1'b0;
      case (r_state)
         ST_IDLE: if (start) begin
            w_accept = 1'b1;
            w_nxt    = ST_SHIFT;
         end
         ST_SHIFT: if (r_cnt == '0) begin
            w_finish = 1'b1;
            w_nxt    = ST_IDLE;
         end
         default: w_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_mag     <= '0;
         r_cnt     <= '0;
         r_dir     <= 1'b0;
         r_byp     <= 1'b0;
         r_inv     <= 1'b0;
         r_sign    <= 1'b0;
         r_result  <= '0;
         r_invalid <= 1'b0;
         r_done    <= 1'b0;
      end else begin
         r_done <= w_finish;
         if (w_accept) begin
            r_mag  <= w_ld_mag;
            r_cnt  <= w_ld_cnt;
            r_dir  <= w_ld_dir;
            r_byp  <= w_ld_byp;
            r_inv  <= w_ld_inv;
            r_sign <= w_f.s;
         end else if (r_state == ST_SHIFT && r_cnt != '0) begin
            r_mag <= r_dir ? (r_mag << 1) : (r_mag >> 1);
            r_cnt <= r_cnt - 5'd1;
         end
         if (w_finish) begin
            r_result  <= (r_byp || !r_sign) ? r_mag : -r_mag;
            r_invalid <= r_inv;
         end
      end
   end

   assign busy    = (r_state != ST_IDLE);
   assign done    = r_done;
   assign result  = r_result;
   assign invalid = r_invalid;
endmodule
